regfile_dw: RTL

//   Parametrised ARM register file with one physical write port and a

---
 rtl/regfile_pkg.sv | 12 +
 rtl/rf_long_seq.sv | 79 +++++++
 rtl/regfile_dw.sv | 99 +++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared defaults and write-sequencer state type for regfile_dw
package regfile_pkg;
   localparam int DEF_DATA_W = 32;
   localparam int DEF_NREG   = 16;
   localparam int DEF_AW     = 4;
   localparam int PC_IDX     = DEF_NREG - 1;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      HI   = 1'b1
   } wr_state_t;
endpackage

// File: rtl/rf_long_seq.sv
// rtl/rf_long_seq.sv - sequences single and 64-bit writes onto one physical write port
module rf_long_seq
   import regfile_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int AW     = DEF_AW
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              we,
   input  logic              wlong,
   input  logic [AW-1:0]     wa_lo,
   input  logic [AW-1:0]     wa_hi,
   input  logic [DATA_W-1:0] wd_lo,
   input  logic [DATA_W-1:0] wd_hi,
   output logic              wr_en,
   output logic [AW-1:0]     wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic              byp_valid,
   output logic [AW-1:0]     byp_addr,
   output logic [DATA_W-1:0] byp_data,
   output logic              busy,
   output logic              ovf
);
   wr_state_t         state_q, state_d;
   logic [AW-1:0]     pend_a_q, pend_a_d;
   logic [DATA_W-1:0] pend_d_q, pend_d_d;
   logic              ovf_q, ovf_d;

   always_comb begin
      state_d  = state_q;
      pend_a_d = pend_a_q;
      pend_d_d = pend_d_q;
      ovf_d    = ovf_q;
      wr_en    = 1'b0;
      wr_addr  = wa_lo;
      wr_data  = wd_lo;
      case (state_q)
         IDLE: begin
            if (we) begin
               wr_en = 1'b1;
               if (wlong) begin
                  pend_a_d = wa_hi;
                  pend_d_d = wd_hi;
                  state_d  = HI;
               end
            end
         end
         default: begin
            // The hi half owns the port this cycle; any new request is lost.
            wr_en   = 1'b1;
            wr_addr = pend_a_q;
            wr_data = pend_d_q;
            state_d = IDLE;
            if (we) ovf_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         pend_a_q <= '0;
         pend_d_q <= '0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         pend_a_q <= pend_a_d;
         pend_d_q <= pend_d_d;
         ovf_q    <= ovf_d;
      end
   end

   assign byp_valid = (state_q == HI);
   assign byp_addr  = pend_a_q;
   assign byp_data  = pend_d_q;
   assign busy      = (state_q == HI);
   assign ovf       = ovf_q;
endmodule

// File: rtl/regfile_dw.sv
// rtl/regfile_dw.sv - register file with one write port, long-write sequencing and PC-mapped top address
module regfile_dw
   import regfile_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int NREG   = DEF_NREG,
   parameter int AW     = DEF_AW,
   parameter bit BYPASS = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              we,
   input  logic              wlong,
   input  logic [AW-1:0]     wa_lo,
   input  logic [AW-1:0]     wa_hi,
   input  logic [DATA_W-1:0] wd_lo,
   input  logic [DATA_W-1:0] wd_hi,
   input  logic [AW-1:0]     ra1,
   input  logic [AW-1:0]     ra2,
   input  logic [DATA_W-1:0] r15,
   output logic [DATA_W-1:0] rd1,
   output logic [DATA_W-1:0] rd2,
   output logic              busy,
   output logic              ovf
);
   localparam int          NSTORE = NREG - 1;
   localparam logic [AW-1:0] PC_A = AW'(NREG - 1);

   logic              wr_en;
   logic [AW-1:0]     wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              byp_valid;
   logic [AW-1:0]     byp_addr;
   logic [DATA_W-1:0] byp_data;

   logic [DATA_W-1:0] rf_q [NSTORE];
   logic [DATA_W-1:0] rf_d [NSTORE];

   rf_long_seq #(.DATA_W(DATA_W), .AW(AW)) u_seq (
      .clk       (clk),
      .reset     (reset),
      .we        (we),
      .wlong     (wlong),
      .wa_lo     (wa_lo),
      .wa_hi     (wa_hi),
      .wd_lo     (wd_lo),
      .wd_hi     (wd_hi),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .byp_valid (byp_valid),
      .byp_addr  (byp_addr),
      .byp_data  (byp_data),
      .busy      (busy),
      .ovf       (ovf)
   );

   // Only stored indices can match, so PC and out-of-range writes fall through untouched.
   always_comb begin
      for (int i = 0; i < NSTORE; i++) begin
         rf_d[i] = rf_q[i];
         if (wr_en && wr_addr == AW'(i)) rf_d[i] = wr_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NSTORE; i++) rf_q[i] <= '0;
      end else begin
         for (int i = 0; i < NSTORE; i++) rf_q[i] <= rf_d[i];
      end
   end

   function automatic logic [DATA_W-1:0] read_port(
      input logic [AW-1:0]     ra,
      input logic [DATA_W-1:0] pc_val,
      input logic              bv,
      input logic [AW-1:0]     ba,
      input logic [DATA_W-1:0] bd,
      input logic [DATA_W-1:0] arr [NSTORE]
   );
      logic [DATA_W-1:0] v;
      v = '0;
      if (ra == PC_A) begin
         v = pc_val;
      end else if (BYPASS && bv && ra == ba && ra < PC_A) begin
         v = bd;
      end else begin
         for (int i = 0; i < NSTORE; i++)
            if (ra == AW'(i)) v = arr[i];
      end
      return v;
   endfunction

   always_comb begin
      rd1 = read_port(ra1, r15, byp_valid, byp_addr, byp_data, rf_q);
      rd2 = read_port(ra2, r15, byp_valid, byp_addr, byp_data, rf_q);
   end
endmodule
